// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART byte-channel scheduler and related arbiters.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package uart_ctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        HOLD
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    // Timeout counters stop at all-ones instead of wrapping back to zero.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_req_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        cand      = '0;
        idx_o     = '0;
        onehot_o  = '0;
        any_req_o = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
        onehot_o[idx_o] = any_req_o;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ message sources, round-robin per message.
// Latency: arbitration cycle k -> tx_start/req_ack/grant visible at k+1; one byte in flight.
// Backpressure: waits for tx_busy low before each start; grant held to the last byte.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BUSY_TO = 4,
    parameter int HOLD_TO = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      err
);

    localparam int   IDX_W    = $clog2(NUM_REQ);
    localparam cnt_t BUSY_LIM = cnt_t'(BUSY_TO - 1);
    localparam cnt_t HOLD_LIM = cnt_t'(HOLD_TO - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    cnt_t               cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   idx_inc;
    logic               issue;
    logic               rel;
    logic [IDX_W-1:0]   issue_idx;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .onehot_o  (pick_onehot),
        .idx_o     (pick_idx),
        .any_req_o (pick_any)
    );

    assign idx_inc = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    // Next-state: arbitrate in IDLE, then pace bytes of the owning requester through the busy handshake.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        start_d   = 1'b0;
        ack_d     = '0;
        err_d     = 1'b0;
        issue     = 1'b0;
        rel       = 1'b0;
        issue_idx = idx_q;

        case (state_q)
            IDLE: begin
                // Never start into a transmitter still finishing a byte (e.g. after reset).
                if (!tx_busy && pick_any) begin
                    issue     = 1'b1;
                    issue_idx = pick_idx;
                    idx_d     = pick_idx;
                    grant_d   = pick_onehot;
                end
            end
            WAIT_HI: begin
                // The tx_start cycle is the first of the BUSY_TO cycles allowed.
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q >= BUSY_LIM) begin
                    err_d = 1'b1;
                    rel   = 1'b1;
                end else begin
                    cnt_d = cnt_sat_inc(cnt_q);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        rel = 1'b1;
                    end else if (req[idx_q]) begin
                        issue = 1'b1;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (req[idx_q]) begin
                    issue = 1'b1;
                end else if (cnt_q >= HOLD_LIM) begin
                    err_d = 1'b1;
                    rel   = 1'b1;
                end else begin
                    cnt_d = cnt_sat_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            start_d           = 1'b1;
            data_d            = req_data[BYTE_W*int'(issue_idx) +: BYTE_W];
            ack_d[issue_idx]  = 1'b1;
            last_d            = req_last[issue_idx];
            cnt_d             = '0;
            state_d           = WAIT_HI;
        end

        if (rel) begin
            grant_d = '0;
            ptr_d   = idx_inc;
            state_d = IDLE;
        end
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            data_q  <= data_d;
            err_q   <= err_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant    = grant_q;
    assign req_ack  = ack_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: message-level scoreboard plus a simple transmitter model.
// Latency: expects busy two cycles after arbitration and start one cycle after it.
// Backpressure: transmitter busy length and requester mid-message gaps are varied.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int BTO = 4;
    localparam int HTO = 8;
    localparam int BIG = 1000000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           err;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ (N),
        .BUSY_TO (BTO),
        .HOLD_TO (HTO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .err      (err)
    );

    int checks   = 0;
    int failures = 0;

    // Requester side: pending bytes and last flags per source.
    logic [7:0] bq[N][$];
    bit         lq[N][$];
    int         gapc[N];
    bit         drop_mid[N];
    int         gap_max;

    // Expected start order (requester index, byte) and the model's rr pointer.
    int         exp_idx[$];
    logic [7:0] exp_byte[$];
    int         model_ptr;

    // Transmitter model.
    bit tx_stub;
    bit busy_pend;
    int busy_rem;
    int busy_min, busy_max;

    int         tick_no, starts, errs;
    int         acks[N];
    int         last_start_tick, last_err_tick, last_fall_tick;
    logic [N-1:0] grant_prev, grant_or, first_grant, grant_at_err, grant_before_err;
    int         s0, e0, a0, n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() > 0) begin
                req[i]           = (gapc[i] == 0);
                req_data[8*i +: 8] = bq[i][0];
                req_last[i]      = lq[i][0];
            end else begin
                req[i]           = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]      = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] b, input bit last);
        bq[i].push_back(b);
        lq[i].push_back(last);
        drive();
    endtask

    // Round-robin at message granularity over everything queued.
    task automatic plan();
        int pos[N];
        bit found;
        int w, sel;
        for (int i = 0; i < N; i++) pos[i] = 0;
        found = 1'b1;
        sel   = 0;
        while (found) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                w = (model_ptr + k) % N;
                if (!found && pos[w] < bq[w].size()) begin
                    found = 1'b1;
                    sel   = w;
                end
            end
            if (found) begin
                do begin
                    exp_idx.push_back(sel);
                    exp_byte.push_back(bq[sel][pos[sel]]);
                    pos[sel]++;
                end while (!lq[sel][pos[sel]-1] && pos[sel] < bq[sel].size());
                model_ptr = (sel + 1) % N;
            end
        end
    endtask

    function automatic bit is_idle();
        bit r;
        r = (exp_idx.size() == 0) && (grant == '0) && !busy_pend && (busy_rem == 0);
        for (int i = 0; i < N; i++) if (bq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic tick();
        int         e;
        logic [7:0] b;
        bit         wasl;
        logic       busy_before;
        @(posedge clk);
        #1;
        tick_no++;
        busy_before = tx_busy;

        if (busy_rem > 0) begin
            busy_rem--;
            if (busy_rem == 0) begin
                tx_busy        = 1'b0;
                last_fall_tick = tick_no;
            end
        end else if (busy_pend) begin
            busy_pend = 1'b0;
            tx_busy   = 1'b1;
            busy_rem  = int'($urandom_range(busy_max, busy_min));
        end

        if (tx_start) begin
            starts++;
            last_start_tick = tick_no;
            if (first_grant == '0) first_grant = grant;
            chk("start_while_busy", 32'(busy_before), 32'd0);
            if (exp_idx.size() == 0) begin
                chk("start_expected", 32'(exp_idx.size()), 32'd1);
            end else begin
                e = exp_idx.pop_front();
                b = exp_byte.pop_front();
                chk("grant_at_start", 32'(grant), 32'(1 << e));
                chk("tx_data", 32'(tx_data), 32'(b));
                chk("ack_with_start", 32'(req_ack), 32'(1 << e));
            end
            if (!tx_stub) busy_pend = 1'b1;
        end else begin
            chk("ack_without_start", 32'(req_ack), 32'd0);
        end

        for (int i = 0; i < N; i++) if (gapc[i] > 0 && gapc[i] < BIG) gapc[i]--;

        for (int i = 0; i < N; i++) begin
            if (req_ack[i] && bq[i].size() > 0) begin
                acks[i]++;
                wasl = lq[i][0];
                void'(bq[i].pop_front());
                void'(lq[i].pop_front());
                if (!wasl && bq[i].size() > 0) begin
                    gapc[i]     = drop_mid[i] ? BIG : int'($urandom_range(gap_max, 0));
                    drop_mid[i] = 1'b0;
                end
            end
        end

        if (err) begin
            errs++;
            last_err_tick    = tick_no;
            grant_at_err     = grant;
            grant_before_err = grant_prev;
            for (int i = 0; i < N; i++) begin
                if (gapc[i] >= BIG) begin
                    bq[i].delete();
                    lq[i].delete();
                    gapc[i] = 0;
                end
            end
        end

        grant_prev = grant;
        grant_or   = grant_or | grant;
        drive();
    endtask

    task automatic run_idle(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!is_idle() && k < 3000);
        chk({tag, "_done"}, 32'(is_idle()), 32'd1);
    endtask

    task automatic begin_test();
        s0          = starts;
        e0          = errs;
        a0          = acks[0];
        grant_or    = '0;
        first_grant = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_busy   = 1'b0;
        req       = '0;
        req_data  = '0;
        req_last  = '0;
        tx_stub   = 1'b0;
        busy_pend = 1'b0;
        busy_rem  = 0;
        busy_min  = 3;
        busy_max  = 3;
        gap_max   = 0;
        model_ptr = 0;
        tick_no   = 0;
        starts    = 0;
        errs      = 0;
        grant_prev = '0;
        grant_or  = '0;
        first_grant = '0;
        grant_at_err = '0;
        grant_before_err = '0;
        last_start_tick = 0;
        last_err_tick = 0;
        last_fall_tick = 0;
        for (int i = 0; i < N; i++) begin
            gapc[i] = 0;
            drop_mid[i] = 1'b0;
            acks[i] = 0;
        end

        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Three-byte message from requester 0.
        begin_test();
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        plan();
        run_idle("t1");
        chk("t1_starts", 32'(starts - s0), 32'd3);
        chk("t1_acks", 32'(acks[0] - a0), 32'd3);
        chk("t1_grant_or", 32'(grant_or), 32'b0001);
        chk("t1_err", 32'(errs - e0), 32'd0);

        // Pointer now at 1: requester 1 beats requester 0.
        begin_test();
        push_byte(0, 8'h10, 1'b1);
        push_byte(1, 8'h11, 1'b1);
        plan();
        run_idle("t1b");
        chk("t1b_first_grant", 32'(first_grant), 32'b0010);

        // Reset puts the pointer back to 0: req0 then req3.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        begin_test();
        push_byte(0, 8'hAA, 1'b1);
        push_byte(3, 8'h55, 1'b1);
        plan();
        run_idle("t2");
        chk("t2_first_grant", 32'(first_grant), 32'b0001);
        chk("t2_grant_or", 32'(grant_or), 32'b1001);

        // Requester 1 stalls mid-message until the hold timeout aborts it.
        begin_test();
        drop_mid[1] = 1'b1;
        push_byte(1, 8'hB1, 1'b0);
        push_byte(1, 8'hB2, 1'b1);
        exp_idx.push_back(1);
        exp_byte.push_back(8'hB1);
        model_ptr = 2;
        run_idle("t4");
        chk("t4_err", 32'(errs - e0), 32'd1);
        chk("t4_hold_len", 32'(last_err_tick - last_fall_tick), 32'(HTO + 1));
        chk("t4_grant_before_err", 32'(grant_before_err), 32'b0010);
        chk("t4_grant_at_err", 32'(grant_at_err), 32'd0);

        // Pointer at 2 after the abort: requester 2 served before requester 1.
        begin_test();
        push_byte(1, 8'h21, 1'b1);
        push_byte(2, 8'h22, 1'b1);
        plan();
        run_idle("t4b");
        chk("t4b_first_grant", 32'(first_grant), 32'b0100);
        push_byte(2, 8'h23, 1'b1);
        plan();
        run_idle("t4c");

        // Pointer at 3 with req0 and req3 pending: wrap order 3 then 0.
        begin_test();
        push_byte(0, 8'h30, 1'b1);
        push_byte(3, 8'h33, 1'b1);
        plan();
        run_idle("t3");
        chk("t3_first_grant", 32'(first_grant), 32'b1000);

        // Transmitter never raises busy: busy timeout.
        begin_test();
        tx_stub = 1'b1;
        push_byte(0, 8'h77, 1'b1);
        exp_idx.push_back(0);
        exp_byte.push_back(8'h77);
        model_ptr = 1;
        run_idle("t5");
        chk("t5_err", 32'(errs - e0), 32'd1);
        chk("t5_err_delay", 32'(last_err_tick - last_start_tick), 32'(BTO));
        repeat (10) tick();
        chk("t5_no_restart", 32'(starts - s0), 32'd1);
        tx_stub = 1'b0;

        // Reset while the transmitter is busy mid-message.
        begin_test();
        busy_min = 6;
        busy_max = 6;
        push_byte(1, 8'h61, 1'b0);
        push_byte(1, 8'h62, 1'b1);
        exp_idx.push_back(1);
        exp_byte.push_back(8'h61);
        n = 0;
        while (tx_busy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_started", 32'(starts - s0), 32'd1);
        tick();
        push_byte(0, 8'h60, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_ack", 32'(req_ack), 32'd0);
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_data", 32'(tx_data), 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        exp_idx.push_back(0);
        exp_byte.push_back(8'h60);
        exp_idx.push_back(1);
        exp_byte.push_back(8'h62);
        model_ptr = 2;
        first_grant = '0;
        run_idle("t6");
        chk("t6_first_grant", 32'(first_grant), 32'b0001);

        // Randomized message mixes with variable busy length and mid-message gaps.
        busy_min = 1;
        busy_max = 4;
        gap_max  = 3;
        for (int r = 0; r < 8; r++) begin
            begin_test();
            for (int i = 0; i < N; i++) begin
                for (int m = 0; m < int'($urandom_range(2, 0)); m++) begin
                    n = int'($urandom_range(3, 1));
                    for (int j = 0; j < n; j++) begin
                        push_byte(i, 8'($urandom), j == n - 1);
                    end
                end
            end
            plan();
            run_idle("rand");
            chk("rand_err", 32'(errs - e0), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
